// File: rtl/decap_poison_filter_pkg.sv
// Shared types for the decapsulator poison filter: FSM states and tuser bit positions.
package decap_poison_filter_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PASS    = 2'd1,
    DRAIN   = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam int TU_POISON = 0;
  localparam int TU_DONE   = 1;

endpackage

// File: rtl/decap_poison_filter_fifo.sv
// Synchronous FIFO that holds the leading packet beats while the parser verdict is pending.
// Pointers carry one extra wrap bit, so full and empty both come from a pointer compare.
module poison_filter_fifo #(
  parameter int WIDTH = 78,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_rd   = rd_en && !empty;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/decap_poison_filter.sv
// Holds each packet's leading beats until the parser verdict arrives, then forwards clean packets
// with tuser stripped or drops the whole packet, reporting the drop cause and a saturating total.
//   state   | meaning
//   COLLECT | buffering beats, verdict not yet known, output held off
//   PASS    | clean verdict, FIFO forwards beats, waiting for tlast
//   DRAIN   | tlast stored, input held off until the FIFO empties
//   DROP    | packet rejected, beats discarded up to and including tlast
module decap_poison_filter
  import decap_poison_filter_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4,
  parameter int BUF_DEPTH      = 8,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [1:0]                  axis_in_tuser,
  input  logic [AXIS_ID_WIDTH:0]      axis_in_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
  input  logic                        axis_in_tlast,
  input  logic                        axis_in_tvalid,
  output logic                        axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]   axis_out_tdata,
  output logic [AXIS_ID_WIDTH:0]      axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0] axis_out_tkeep,
  output logic                        axis_out_tlast,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready,
  output logic                        drop_poison,
  output logic                        drop_unparsed,
  output logic                        drop_overflow,
  output logic [CNT_WIDTH-1:0]        drop_count
);

  localparam int KW    = AXIS_BUS_WIDTH / 8;
  localparam int FW    = AXIS_BUS_WIDTH + AXIS_ID_WIDTH + 1 + KW + 1;
  localparam int PTR_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [PTR_W-1:0]     FILL_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t           state, state_nxt;
  logic             sticky_poison;
  logic             run;
  logic             beat;
  logic             fifo_wr, fifo_clr, fifo_rd;
  logic             fifo_full, fifo_empty;
  logic [PTR_W-1:0] fifo_count;
  logic [FW-1:0]    fifo_rdata;
  logic             ev_poison, ev_unparsed, ev_overflow;

  // run keeps in_tready low while reset is asserted and for the first cycle after it.
  always_comb begin
    axis_in_tready = 1'b0;
    if (run) begin
      case (state)
        COLLECT, PASS: axis_in_tready = !fifo_full;
        DROP:          axis_in_tready = 1'b1;
        default:       axis_in_tready = 1'b0;
      endcase
    end
  end

  assign beat            = axis_in_tvalid && axis_in_tready;
  assign axis_out_tvalid = ((state == PASS) || (state == DRAIN)) && !fifo_empty;
  assign fifo_rd         = axis_out_tvalid && axis_out_tready;
  assign {axis_out_tdata, axis_out_tdest, axis_out_tkeep, axis_out_tlast} = fifo_rdata;

  always_comb begin
    state_nxt   = state;
    fifo_wr     = 1'b0;
    fifo_clr    = 1'b0;
    ev_poison   = 1'b0;
    ev_unparsed = 1'b0;
    ev_overflow = 1'b0;
    case (state)
      COLLECT: if (beat) begin
        if (!axis_in_tuser[TU_DONE]) begin
          if (axis_in_tlast) begin
            fifo_clr    = 1'b1;
            ev_unparsed = 1'b1;
          end else if (fifo_count == FILL_LAST) begin
            fifo_clr    = 1'b1;
            ev_overflow = 1'b1;
            state_nxt   = DROP;
          end else begin
            fifo_wr = 1'b1;
          end
        end else if (sticky_poison || axis_in_tuser[TU_POISON]) begin
          fifo_clr  = 1'b1;
          ev_poison = 1'b1;
          state_nxt = axis_in_tlast ? COLLECT : DROP;
        end else begin
          fifo_wr   = 1'b1;
          state_nxt = axis_in_tlast ? DRAIN : PASS;
        end
      end
      PASS: if (beat) begin
        fifo_wr = 1'b1;
        if (axis_in_tlast) state_nxt = DRAIN;
      end
      DRAIN: if (fifo_empty) state_nxt = COLLECT;
      DROP:  if (beat && axis_in_tlast) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= COLLECT;
      sticky_poison <= 1'b0;
      run           <= 1'b0;
      drop_poison   <= 1'b0;
      drop_unparsed <= 1'b0;
      drop_overflow <= 1'b0;
      drop_count    <= '0;
    end else begin
      state         <= state_nxt;
      run           <= 1'b1;
      drop_poison   <= ev_poison;
      drop_unparsed <= ev_unparsed;
      drop_overflow <= ev_overflow;
      if (beat) sticky_poison <= !axis_in_tlast && (sticky_poison || axis_in_tuser[TU_POISON]);
      if ((ev_poison || ev_unparsed || ev_overflow) && !(&drop_count))
        drop_count <= drop_count + CNT_ONE;
    end
  end

  poison_filter_fifo #(
    .WIDTH (FW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .clear   (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data ({axis_in_tdata, axis_in_tdest, axis_in_tkeep, axis_in_tlast}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
